// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg -- shared encodings for the ID/EX pipeline register.
// Holds the ALU control codes produced by the decoder, the main-decoder
// alu_op classes, the funct3 values the ALU decoder recognises, and the
// forwarding-select encodings used by the operand muxes.
package id_ex_stage_pkg;

  // ALU control codes driven to the execute stage
  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_PASS_A = 4'b1111;

  // Instruction class from the main decoder
  typedef enum logic [1:0] {
    ALU_OP_MEM    = 2'b00,
    ALU_OP_BRANCH = 2'b01,
    ALU_OP_RTYPE  = 2'b10,
    ALU_OP_ITYPE  = 2'b11
  } alu_op_e;

  // funct3 values with a supported ALU operation
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // Operand source selection from the forwarding unit
  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,
    FWD_MEM    = 2'b01,
    FWD_WB     = 2'b10,
    FWD_RF_ALT = 2'b11
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_alu_decoder.sv
// alu_decoder -- combinational ALU control decoder.
// Ports:
//   alu_op   [1:0] instruction class from the main decoder
//   funct3   [2:0] instruction funct3 field
//   funct7b5       bit 5 of funct7 (selects SUB for R-type only)
//   alu_ctrl [3:0] ALU control code
module alu_decoder
  import id_ex_stage_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_PASS_A;
    case (alu_op_e'(alu_op))
      ALU_OP_MEM:    alu_ctrl = ALU_ADD;
      ALU_OP_BRANCH: alu_ctrl = ALU_SUB;
      ALU_OP_RTYPE: begin
        case (funct3)
          F3_ADD_SUB: alu_ctrl = funct7b5 ? ALU_SUB : ALU_ADD;
          F3_AND:     alu_ctrl = ALU_AND;
          F3_OR:      alu_ctrl = ALU_OR;
          default:    alu_ctrl = ALU_PASS_A;
        endcase
      end
      ALU_OP_ITYPE: begin
        // funct7b5 belongs to the immediate for I-type, so ADDI never subtracts
        case (funct3)
          F3_ADD_SUB: alu_ctrl = ALU_ADD;
          F3_AND:     alu_ctrl = ALU_AND;
          F3_OR:      alu_ctrl = ALU_OR;
          default:    alu_ctrl = ALU_PASS_A;
        endcase
      end
      default: alu_ctrl = ALU_PASS_A;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register with operand forwarding and ALU decode.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   in_valid / in_ready               decode-side handshake
//   in_rs1_data, in_rs2_data, in_imm, in_pc   operands, immediate, PC
//   in_alu_op, in_funct3, in_funct7b5, in_alu_src   ALU decode fields
//   in_rd, in_reg_write, in_mem_read, in_mem_write, in_branch   sideband
//   fwd_a, fwd_b, mem_fwd_data, wb_fwd_data   forwarding selects and sources
//   flush                             drop held and incoming instruction
//   out_valid / out_ready             execute-side handshake
//   out_a, out_b, out_store_data, out_pc, out_alu_ctrl   registered payload
//   out_rd, out_reg_write, out_mem_read, out_mem_write, out_branch
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [1:0]      in_alu_op,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic            in_alu_src,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_write,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  input  logic            in_branch,
  input  logic [1:0]      fwd_a,
  input  logic [1:0]      fwd_b,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic [XLEN-1:0] wb_fwd_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [XLEN-1:0] out_store_data,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      out_alu_ctrl,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch
);

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic [3:0]      alu_ctrl_next;
  logic            transfer;
  logic            valid_next;

  logic            valid_reg;
  logic [XLEN-1:0] a_reg;
  logic [XLEN-1:0] b_reg;
  logic [XLEN-1:0] store_data_reg;
  logic [XLEN-1:0] pc_reg;
  logic [3:0]      alu_ctrl_reg;
  logic [4:0]      rd_reg;
  logic            reg_write_reg;
  logic            mem_read_reg;
  logic            mem_write_reg;
  logic            branch_reg;

  // Operand forwarding; both 00 and 11 fall back to the register file
  always_comb begin
    fwd_rs1 = in_rs1_data;
    case (fwd_sel_e'(fwd_a))
      FWD_MEM: fwd_rs1 = mem_fwd_data;
      FWD_WB:  fwd_rs1 = wb_fwd_data;
      default: fwd_rs1 = in_rs1_data;
    endcase
  end

  always_comb begin
    fwd_rs2 = in_rs2_data;
    case (fwd_sel_e'(fwd_b))
      FWD_MEM: fwd_rs2 = mem_fwd_data;
      FWD_WB:  fwd_rs2 = wb_fwd_data;
      default: fwd_rs2 = in_rs2_data;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op   (in_alu_op),
    .funct3   (in_funct3),
    .funct7b5 (in_funct7b5),
    .alu_ctrl (alu_ctrl_next)
  );

  // flush is folded into in_ready so it also blocks the transfer
  assign in_ready = (!valid_reg || out_ready) && !flush;
  assign transfer = in_valid && in_ready;

  always_comb begin
    valid_next = valid_reg;
    if (flush)
      valid_next = 1'b0;
    else if (transfer)
      valid_next = 1'b1;
    else if (out_ready)
      valid_next = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg      <= 1'b0;
      a_reg          <= '0;
      b_reg          <= '0;
      store_data_reg <= '0;
      pc_reg         <= '0;
      alu_ctrl_reg   <= ALU_ADD;
      rd_reg         <= '0;
      reg_write_reg  <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      branch_reg     <= 1'b0;
    end else begin
      valid_reg <= valid_next;
      if (transfer) begin
        a_reg          <= fwd_rs1;
        b_reg          <= in_alu_src ? in_imm : fwd_rs2;
        store_data_reg <= fwd_rs2;
        pc_reg         <= in_pc;
        alu_ctrl_reg   <= alu_ctrl_next;
        rd_reg         <= in_rd;
        reg_write_reg  <= in_reg_write;
        mem_read_reg   <= in_mem_read;
        mem_write_reg  <= in_mem_write;
        branch_reg     <= in_branch;
      end
    end
  end

  assign out_valid      = valid_reg;
  assign out_a          = a_reg;
  assign out_b          = b_reg;
  assign out_store_data = store_data_reg;
  assign out_pc         = pc_reg;
  assign out_alu_ctrl   = alu_ctrl_reg;
  assign out_rd         = rd_reg;
  // Side-effecting controls are masked so a stale payload can never commit
  assign out_reg_write  = reg_write_reg & valid_reg;
  assign out_mem_read   = mem_read_reg  & valid_reg;
  assign out_mem_write  = mem_write_reg & valid_reg;
  assign out_branch     = branch_reg    & valid_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage -- directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

  localparam int XLEN = 32;

  logic            clk;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [XLEN-1:0] in_imm;
  logic [XLEN-1:0] in_pc;
  logic [1:0]      in_alu_op;
  logic [2:0]      in_funct3;
  logic            in_funct7b5;
  logic            in_alu_src;
  logic [4:0]      in_rd;
  logic            in_reg_write;
  logic            in_mem_read;
  logic            in_mem_write;
  logic            in_branch;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic [XLEN-1:0] mem_fwd_data;
  logic [XLEN-1:0] wb_fwd_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [XLEN-1:0] out_store_data;
  logic [XLEN-1:0] out_pc;
  logic [3:0]      out_alu_ctrl;
  logic [4:0]      out_rd;
  logic            out_reg_write;
  logic            out_mem_read;
  logic            out_mem_write;
  logic            out_branch;

  int pass_cnt  = 0;
  int total_cnt = 0;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rs1_data    (in_rs1_data),
    .in_rs2_data    (in_rs2_data),
    .in_imm         (in_imm),
    .in_pc          (in_pc),
    .in_alu_op      (in_alu_op),
    .in_funct3      (in_funct3),
    .in_funct7b5    (in_funct7b5),
    .in_alu_src     (in_alu_src),
    .in_rd          (in_rd),
    .in_reg_write   (in_reg_write),
    .in_mem_read    (in_mem_read),
    .in_mem_write   (in_mem_write),
    .in_branch      (in_branch),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .mem_fwd_data   (mem_fwd_data),
    .wb_fwd_data    (wb_fwd_data),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_a          (out_a),
    .out_b          (out_b),
    .out_store_data (out_store_data),
    .out_pc         (out_pc),
    .out_alu_ctrl   (out_alu_ctrl),
    .out_rd         (out_rd),
    .out_reg_write  (out_reg_write),
    .out_mem_read   (out_mem_read),
    .out_mem_write  (out_mem_write),
    .out_branch     (out_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load a register-file-sourced instruction onto the decode-side inputs
  task automatic set_instr(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] rs1);
    in_pc        = pc;
    in_rd        = rd;
    in_rs1_data  = rs1;
    in_rs2_data  = 32'h0;
    in_imm       = 32'h0;
    in_alu_op    = 2'b10;
    in_funct3    = 3'b000;
    in_funct7b5  = 1'b0;
    in_alu_src   = 1'b0;
    in_reg_write = 1'b1;
    in_mem_read  = 1'b0;
    in_mem_write = 1'b0;
    in_branch    = 1'b0;
    fwd_a        = 2'b00;
    fwd_b        = 2'b00;
  endtask

  task automatic test_reset();
    tick();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_alu_ctrl !== 4'b0010) $display("FAIL reset_alu_ctrl got=%b exp=0010", out_alu_ctrl);
    else pass_cnt++;
    total_cnt++;
    if ({out_a, out_b, out_store_data, out_pc} !== 128'h0)
      $display("FAIL reset_data got=%h/%h/%h/%h exp=0", out_a, out_b, out_store_data, out_pc);
    else pass_cnt++;
    total_cnt++;
    if ({out_rd, out_reg_write, out_mem_read, out_mem_write, out_branch} !== 9'h0)
      $display("FAIL reset_sideband got=%h exp=0", {out_rd, out_reg_write, out_mem_read, out_mem_write, out_branch});
    else pass_cnt++;

    // Release, load one instruction, then reset asynchronously mid-stream
    reset_n   = 1'b1;
    out_ready = 1'b1;
    set_instr(32'h40, 5'd9, 32'h5);
    in_mem_write = 1'b1;
    in_valid  = 1'b1;
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_a !== 32'h5 || out_rd !== 5'd9)
      $display("FAIL first_accept got=%b/%h/%0d exp=1/00000005/9", out_valid, out_a, out_rd);
    else pass_cnt++;

    reset_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || out_alu_ctrl !== 4'b0010 || out_a !== 32'h0 || out_pc !== 32'h0 || out_mem_write !== 1'b0)
      $display("FAIL async_reset got=%b/%b/%h/%h/%b exp=0/0010/0/0/0", out_valid, out_alu_ctrl, out_a, out_pc, out_mem_write);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL held_in_reset got=%b exp=0", out_valid);
    else pass_cnt++;
    reset_n = 1'b1;
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40) $display("FAIL post_release got=%b/%h exp=1/00000040", out_valid, out_pc);
    else pass_cnt++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_decode();
    logic [1:0] ops [10];
    logic [2:0] f3s [10];
    logic       f7s [10];
    logic [3:0] exps[10];
    ops  = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b10};
    f3s  = '{3'b000, 3'b111, 3'b110, 3'b001, 3'b101, 3'b011, 3'b000, 3'b000, 3'b110, 3'b010};
    f7s  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exps = '{4'b0110, 4'b0000, 4'b0001, 4'b1111, 4'b0010, 4'b0110, 4'b0010, 4'b0010, 4'b0001, 4'b1111};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_instr(32'h100 + i, 5'd1, 32'h0);
      in_alu_op   = ops[i];
      in_funct3   = f3s[i];
      in_funct7b5 = f7s[i];
      tick();
      total_cnt++;
      if (out_alu_ctrl !== exps[i])
        $display("FAIL decode_%0d op=%b f3=%b f7=%b got=%b exp=%b", i, ops[i], f3s[i], f7s[i], out_alu_ctrl, exps[i]);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_forwarding();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_instr(32'h200, 5'd2, 32'h11);
    in_rs2_data  = 32'h44;
    mem_fwd_data = 32'h22;
    wb_fwd_data  = 32'h33;
    fwd_a        = 2'b01;
    fwd_b        = 2'b10;
    in_alu_src   = 1'b1;
    in_imm       = 32'hFFFF_FFFC;
    tick();
    total_cnt++;
    if (out_a !== 32'h22 || out_b !== 32'hFFFF_FFFC || out_store_data !== 32'h33)
      $display("FAIL fwd_mem_wb_imm got=%h/%h/%h exp=00000022/fffffffc/00000033", out_a, out_b, out_store_data);
    else pass_cnt++;

    fwd_a      = 2'b10;
    fwd_b      = 2'b11;
    in_alu_src = 1'b0;
    tick();
    total_cnt++;
    if (out_a !== 32'h33 || out_b !== 32'h44 || out_store_data !== 32'h44)
      $display("FAIL fwd_wb_rf got=%h/%h/%h exp=00000033/00000044/00000044", out_a, out_b, out_store_data);
    else pass_cnt++;

    fwd_a = 2'b00;
    fwd_b = 2'b01;
    tick();
    total_cnt++;
    if (out_a !== 32'h11 || out_b !== 32'h22 || out_store_data !== 32'h22)
      $display("FAIL fwd_rf_mem got=%h/%h/%h exp=00000011/00000022/00000022", out_a, out_b, out_store_data);
    else pass_cnt++;

    fwd_a = 2'b11;
    fwd_b = 2'b00;
    in_rs1_data = 32'h8000_0001;
    tick();
    total_cnt++;
    if (out_a !== 32'h8000_0001 || out_b !== 32'h44)
      $display("FAIL fwd_rf_alt got=%h/%h exp=80000001/00000044", out_a, out_b);
    else pass_cnt++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_instr(32'h100, 5'd3, 32'hA);
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100) $display("FAIL bp_load got=%b/%h exp=1/00000100", out_valid, out_pc);
    else pass_cnt++;

    out_ready = 1'b0;
    set_instr(32'h200, 5'd7, 32'hB);
    for (int c = 0; c < 3; c++) begin
      #1;
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL bp_in_ready_%0d got=%b exp=0", c, in_ready);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_rd !== 5'd3 || out_a !== 32'hA || out_reg_write !== 1'b1)
        $display("FAIL bp_hold_%0d got=%b/%h/%0d/%h exp=1/00000100/3/0000000a", c, out_valid, out_pc, out_rd, out_a);
      else pass_cnt++;
    end

    out_ready = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_rd !== 5'd7)
      $display("FAIL bp_no_bubble got=%b/%h/%0d exp=1/00000200/7", out_valid, out_pc, out_rd);
    else pass_cnt++;

    in_valid = 1'b0;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0 || out_reg_write !== 1'b0)
      $display("FAIL bp_drain got=%b/%b exp=0/0", out_valid, out_reg_write);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_instr(32'h300 + 32'(i * 4), 5'(i + 10), 32'h0);
      tick();
      total_cnt++;
      if (out_valid !== 1'b1 || out_pc !== 32'h300 + 32'(i * 4) || out_rd !== 5'(i + 10))
        $display("FAIL b2b_%0d got=%b/%h/%0d exp=1/%h/%0d", i, out_valid, out_pc, out_rd, 32'h300 + 32'(i * 4), i + 10);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_instr(32'h400, 5'd4, 32'h1);
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_reg_write !== 1'b1) $display("FAIL flush_load got=%b/%b exp=1/1", out_valid, out_reg_write);
    else pass_cnt++;

    out_ready = 1'b0;
    flush     = 1'b1;
    set_instr(32'h500, 5'd5, 32'h2);
    #1;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL flush_in_ready got=%b exp=0", in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0 || out_reg_write !== 1'b0)
      $display("FAIL flush_clear got=%b/%b exp=0/0", out_valid, out_reg_write);
    else pass_cnt++;

    // Flush also outranks a transfer while the stage is empty
    out_ready = 1'b1;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL flush_blocks_transfer got=%b exp=0", out_valid);
    else pass_cnt++;

    flush = 1'b0;
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_pc !== 32'h500) $display("FAIL flush_resume got=%b/%h exp=1/00000500", out_valid, out_pc);
    else pass_cnt++;
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    reset_n      = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    flush        = 1'b0;
    mem_fwd_data = '0;
    wb_fwd_data  = '0;
    set_instr(32'h0, 5'd0, 32'h0);
    in_reg_write = 1'b0;

    test_reset();
    test_decode();
    test_forwarding();
    test_backpressure();
    test_back_to_back();
    test_flush();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of operands, immediate and PC.
REQ-002 Port clk  input  1  rising-edge clock.
REQ-003 Port reset_n  input  1  asynchronous active-low reset.
REQ-004 Port in_valid / in_ready  input / output  1 / 1  decode-side handshake.
REQ-005 Port in_rs1_data, in_rs2_data, in_imm, in_pc  input  XLEN each  register-file operands, sign-extended immediate, instruction PC.
REQ-006 Port in_alu_op  input  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
REQ-007 Port in_funct3 / in_funct7b5 / in_alu_src  input  3 / 1 / 1  instruction fields; alu_src=1 selects immediate as operand B.
REQ-008 Port in_rd / in_reg_write / in_mem_read / in_mem_write / in_branch  input  5/1/1/1/1  sideband controls.
REQ-009 Port fwd_a / fwd_b  input  2 each  00 register file, 01 mem_fwd_data, 10 wb_fwd_data, 11 register file.
REQ-010 Port mem_fwd_data / wb_fwd_data  input  XLEN each  forwarding sources.
REQ-011 Port flush  input  1  discard held and incoming instruction.
REQ-012 Port out_valid / out_ready  output / input  1 / 1  execute-side handshake.
REQ-013 Port out_a, out_b, out_store_data, out_pc  output  XLEN each  ALU A, ALU B, forwarded rs2 for stores, PC.
REQ-014 Port out_alu_ctrl  output  4  ALU control code; out_rd/out_reg_write/out_mem_read/out_mem_write/out_branch registered sideband.

Function
REQ-015 in_ready SHALL equal (!out_valid || out_ready) && !flush; transfer occurs when in_valid && in_ready.
REQ-016 On transfer, all out_* payload SHALL register on the same edge; latency one cycle, out_valid=1 next cycle.
REQ-017 When out_valid && !out_ready, all outputs SHALL hold stable; no input accepted.
REQ-018 When out_valid && out_ready && !in_valid, out_valid SHALL clear next edge; payload may hold its old value.
REQ-019 Simultaneous output consume and input transfer SHALL replace the payload with no bubble.
REQ-020 flush SHALL clear out_valid next edge regardless of out_ready/in_valid; flush outranks transfer.
REQ-021 Forwarded rs1 = mux(fwd_a), forwarded rs2 = mux(fwd_b), sampled at the transfer edge.
REQ-022 out_a = forwarded rs1; out_b = in_alu_src ? in_imm : forwarded rs2; out_store_data = forwarded rs2 always.
REQ-023 ALU codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1111 pass-A (unsupported).
REQ-024 alu_op 00 -> 0010; 01 -> 0110.
REQ-025 alu_op 10: funct3 000 with funct7b5 0 -> 0010, with 1 -> 0110; 111 -> 0000; 110 -> 0001; other -> 1111.
REQ-026 alu_op 11: funct3 000 -> 0010 (funct7b5 ignored); 111 -> 0000; 110 -> 0001; other -> 1111.
REQ-027 When out_valid=0, out_reg_write, out_mem_read, out_mem_write, out_branch SHALL read 0.
REQ-028 Payload arithmetic none; all widths XLEN, no truncation.

Reset
REQ-029 While reset_n=0: out_valid=0, all sideband 0, out_alu_ctrl=0010, all data outputs 0, out_rd=0.
REQ-030 Reset asserted mid-transfer SHALL drop the instruction; first acceptance possible on first edge after release.

Structure
REQ-031 Shared package SHALL hold ALU control code constants, alu_op encodings and forward-select encodings, reused by the ALU and forwarding unit.
REQ-032 One combinational sub-module alu_decoder (alu_op, funct3, funct7b5 -> 4-bit code) SHALL be instantiated; registers live in id_ex_stage.

Verification
REQ-033 Reset: reset_n=0 mid-stream -> out_valid=0, out_alu_ctrl=0010, outputs 0; release, in_valid=1 -> out_valid=1 one edge later.
REQ-034 Decode sweep: alu_op=10, funct3=000, funct7b5=1 -> 0110; funct3=111 -> 0000; alu_op=11, funct3=110 -> 0001; funct3=001 -> 1111.
REQ-035 Forwarding: rs1=0x11, mem_fwd=0x22, wb_fwd=0x33, fwd_a=01, fwd_b=10, alu_src=1, imm=0xFFFFFFFC -> out_a=0x22, out_b=0xFFFFFFFC, out_store_data=0x33.
REQ-036 Backpressure: out_ready=0 three cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> next instruction loads same edge, no bubble.
REQ-037 Flush: flush=1 with out_valid=1, in_valid=1, out_ready=0 -> out_valid=0 next edge, in_ready=0 during flush, out_reg_write=0.
